// File: rtl/walk_pkg.sv
// rtl/walk_pkg.sv - shared defaults, FSM encoding and helpers for the walk request bank
package walk_pkg;

   localparam int DEF_N_CH          = 4;
   localparam int DEF_WAIT_W        = 8;
   localparam int DEF_URGENT_THRESH = 200;
   localparam int DEF_EDGE_MODE     = 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } walk_state_t;

   // Pointer width that stays legal for a single-channel bank.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wr_channel.sv
// rtl/wr_channel.sv - one pedestrian channel: edge detect, sticky pending latch, saturating wait counter
module wr_channel
   import walk_pkg::*;
#(
   parameter int WAIT_W        = DEF_WAIT_W,
   parameter int URGENT_THRESH = DEF_URGENT_THRESH,
   parameter int EDGE_MODE     = DEF_EDGE_MODE
) (
   input  logic Clk,
   input  logic Reset,
   input  logic sync,
   input  logic clear,
   output logic wr,
   output logic urgent
);

   logic              sync_q;
   logic              set_req;
   logic [WAIT_W-1:0] wait_cnt;

   // History resets low so a button held through reset counts as a fresh press.
   assign set_req = (EDGE_MODE != 0) ? (sync & ~sync_q) : sync;
   assign urgent  = (wait_cnt >= WAIT_W'(URGENT_THRESH));

   // Pending latch and wait counter; clear beats set and zeroes the counter.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync_q   <= 1'b0;
         wr       <= 1'b0;
         wait_cnt <= '0;
      end else begin
         sync_q <= sync;
         if (clear) begin
            wr       <= 1'b0;
            wait_cnt <= '0;
         end else begin
            if (set_req) begin
               wr <= 1'b1;
            end
            if (wr && (wait_cnt != '1)) begin
               wait_cnt <= wait_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/walk_request_bank.sv
// rtl/walk_request_bank.sv - pedestrian request bank with urgency-aware round-robin grant FSM
module walk_request_bank
   import walk_pkg::*;
#(
   parameter int N_CH          = DEF_N_CH,
   parameter int WAIT_W        = DEF_WAIT_W,
   parameter int URGENT_THRESH = DEF_URGENT_THRESH,
   parameter int EDGE_MODE     = DEF_EDGE_MODE
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic [N_CH-1:0]              WR_Sync,
   input  logic [N_CH-1:0]              WR_Clear,
   input  logic                         Grant_Ack,
   output logic [N_CH-1:0]              WR,
   output logic [N_CH-1:0]              Grant,
   output logic                         Grant_Valid,
   output logic [N_CH-1:0]              Urgent,
   output logic                         Any_Urgent,
   output logic [$clog2(N_CH+1)-1:0]    Pending_Count
);

   localparam int PTR_W = ptr_width(N_CH);
   localparam int CNT_W = $clog2(N_CH + 1);

   walk_state_t       state, state_next;
   logic [PTR_W-1:0]  ptr, ptr_next;
   logic [PTR_W-1:0]  gnt_idx;
   logic [N_CH-1:0]   grant_next;
   logic [N_CH-1:0]   chan_clear;
   logic [N_CH-1:0]   sel_mask;
   logic [N_CH-1:0]   sel_onehot;

   // An ack only serves the granted channel, and only while a grant is live.
   assign chan_clear = WR_Clear | (((state == ST_GRANT) && Grant_Ack) ? Grant : '0);
   assign Any_Urgent = |Urgent;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      wr_channel #(
         .WAIT_W        (WAIT_W),
         .URGENT_THRESH (URGENT_THRESH),
         .EDGE_MODE     (EDGE_MODE)
      ) u_ch (
         .Clk    (Clk),
         .Reset  (Reset),
         .sync   (WR_Sync[i]),
         .clear  (chan_clear[i]),
         .wr     (WR[i]),
         .urgent (Urgent[i])
      );
   end

   // Popcount of pending requests.
   always_comb begin
      Pending_Count = '0;
      for (int i = 0; i < N_CH; i++) begin
         Pending_Count = Pending_Count + CNT_W'(WR[i]);
      end
   end

   // Pick urgent pending channels first, then round-robin from ptr upward;
   // scanning backwards lets the nearest hit to ptr win the last overwrite.
   always_comb begin
      int idx;
      sel_mask   = (|(WR & Urgent)) ? (WR & Urgent) : WR;
      sel_onehot = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= N_CH) begin
            idx = idx - N_CH;
         end
         if (sel_mask[idx]) begin
            sel_onehot      = '0;
            sel_onehot[idx] = 1'b1;
         end
      end
   end

   // Index of the currently granted channel, used to advance ptr on ack.
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (Grant[i]) begin
            gnt_idx = PTR_W'(i);
         end
      end
   end

   // Grant FSM next-state: issue from IDLE, hold until ack or withdrawal.
   always_comb begin
      state_next = state;
      grant_next = Grant;
      ptr_next   = ptr;
      case (state)
         ST_IDLE: begin
            if (|WR) begin
               grant_next = sel_onehot;
               state_next = ST_GRANT;
            end else begin
               grant_next = '0;
            end
         end
         ST_GRANT: begin
            if (Grant_Ack) begin
               grant_next = '0;
               state_next = ST_IDLE;
               ptr_next   = (gnt_idx == PTR_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
            end else if (|(WR_Clear & Grant)) begin
               grant_next = '0;
               state_next = ST_IDLE;
            end
         end
         default: begin
            grant_next = '0;
            state_next = ST_IDLE;
         end
      endcase
   end

   // Grant FSM state, pointer and registered grant outputs.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= ST_IDLE;
         ptr         <= '0;
         Grant       <= '0;
         Grant_Valid <= 1'b0;
      end else begin
         state       <= state_next;
         ptr         <= ptr_next;
         Grant       <= grant_next;
         Grant_Valid <= |grant_next;
      end
   end

endmodule

// File: tb/tb_walk_request_bank.sv
// tb/tb_walk_request_bank.sv - table-driven scoreboard bench for walk_request_bank
module tb_walk_request_bank;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [3:0] WR_Sync;
   logic [3:0] WR_Clear;
   logic       Grant_Ack;
   logic [3:0] WR;
   logic [3:0] Grant;
   logic       Grant_Valid;
   logic [3:0] Urgent;
   logic       Any_Urgent;
   logic [2:0] Pending_Count;

   always #5 Clk = ~Clk;

   walk_request_bank #(
      .N_CH          (4),
      .WAIT_W        (4),
      .URGENT_THRESH (10),
      .EDGE_MODE     (1)
   ) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .WR_Sync       (WR_Sync),
      .WR_Clear      (WR_Clear),
      .Grant_Ack     (Grant_Ack),
      .WR            (WR),
      .Grant         (Grant),
      .Grant_Valid   (Grant_Valid),
      .Urgent        (Urgent),
      .Any_Urgent    (Any_Urgent),
      .Pending_Count (Pending_Count)
   );

   typedef struct {
      string      tag;
      logic       rst;
      logic [3:0] sync;
      logic [3:0] clr;
      logic       ack;
      logic [3:0] wr;
      logic [3:0] gnt;
      logic [3:0] urg;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic void add(input string tag, input logic rst, input logic [3:0] sync,
                               input logic [3:0] clr, input logic ack, input logic [3:0] wr,
                               input logic [3:0] gnt, input logic [3:0] urg);
      vec_t v;
      v.tag = tag; v.rst = rst; v.sync = sync; v.clr = clr; v.ack = ack;
      v.wr = wr; v.gnt = gnt; v.urg = urg;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t e;
      Reset = 1'b1; WR_Sync = '0; WR_Clear = '0; Grant_Ack = 1'b0;

      // single request, grant, ack; ack in IDLE; pending count ramp; RR after ack; sync held high
      add("a0",  1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000);
      add("a1",  0, 4'b0010, 4'b0000, 0, 4'b0010, 4'b0000, 4'b0000);
      add("a2",  0, 4'b0000, 4'b0000, 0, 4'b0010, 4'b0010, 4'b0000);
      add("a3",  0, 4'b0000, 4'b0000, 0, 4'b0010, 4'b0010, 4'b0000);
      add("a4",  0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000);
      add("a5",  0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000);
      add("a6",  0, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0000, 4'b0000);
      add("a7",  0, 4'b0011, 4'b0000, 0, 4'b0011, 4'b0001, 4'b0000);
      add("a8",  0, 4'b0111, 4'b0000, 0, 4'b0111, 4'b0001, 4'b0000);
      add("a9",  0, 4'b1111, 4'b0000, 0, 4'b1111, 4'b0001, 4'b0000);
      add("a10", 0, 4'b1111, 4'b0000, 1, 4'b1110, 4'b0000, 4'b0000);
      add("a11", 0, 4'b1111, 4'b0000, 0, 4'b1110, 4'b0010, 4'b0000);
      add("a12", 0, 4'b1111, 4'b0000, 1, 4'b1100, 4'b0000, 4'b0000);
      add("a13", 0, 4'b1111, 4'b0000, 0, 4'b1100, 4'b0100, 4'b0000);
      add("a14", 0, 4'b1111, 4'b0000, 1, 4'b1000, 4'b0000, 4'b0000);
      add("a15", 0, 4'b1111, 4'b0000, 0, 4'b1000, 4'b1000, 4'b0000);
      add("a16", 0, 4'b1111, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000);
      add("a17", 0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000);

      // urgency: ch0 granted and held, both waits climb past 10 and saturate at 15
      add("c1",  0, 4'b1001, 4'b0000, 0, 4'b1001, 4'b0000, 4'b0000);
      add("c2",  0, 4'b0000, 4'b0000, 0, 4'b1001, 4'b0001, 4'b0000);
      for (int n = 3; n <= 18; n++) begin
         add($sformatf("c%0d", n), 0, 4'b0000, 4'b0000, 0, 4'b1001, 4'b0001,
             ((n - 1) >= 10) ? 4'b1001 : 4'b0000);
      end
      add("c19", 0, 4'b0010, 4'b0000, 1, 4'b1010, 4'b0000, 4'b1000);
      add("c20", 0, 4'b0000, 4'b0000, 0, 4'b1010, 4'b1000, 4'b1000);
      add("c21", 0, 4'b0000, 4'b0000, 1, 4'b0010, 4'b0000, 4'b0000);
      add("c22", 0, 4'b0000, 4'b0000, 0, 4'b0010, 4'b0010, 4'b0000);
      add("c23", 0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000);

      // withdrawal keeps ptr; clear beats a same-cycle rising edge
      add("b1",  0, 4'b1000, 4'b0000, 0, 4'b1000, 4'b0000, 4'b0000);
      add("b2",  0, 4'b0000, 4'b0000, 0, 4'b1000, 4'b1000, 4'b0000);
      add("b3",  0, 4'b0000, 4'b1000, 0, 4'b0000, 4'b0000, 4'b0000);
      add("b4",  0, 4'b0101, 4'b0000, 0, 4'b0101, 4'b0000, 4'b0000);
      add("b5",  0, 4'b0000, 4'b0000, 0, 4'b0101, 4'b0100, 4'b0000);
      add("b6",  0, 4'b1000, 4'b1000, 0, 4'b0101, 4'b0100, 4'b0000);
      add("b7",  0, 4'b0000, 4'b0100, 0, 4'b0001, 4'b0000, 4'b0000);
      add("b8",  0, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0001, 4'b0000);
      add("b9",  0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000);

      // reset mid-grant overrides ack/sync; button held across release counts as an edge
      add("d1",  0, 4'b0101, 4'b0000, 0, 4'b0101, 4'b0000, 4'b0000);
      add("d2",  0, 4'b0000, 4'b0000, 0, 4'b0101, 4'b0100, 4'b0000);
      add("d3",  1, 4'b0001, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000);
      add("d4",  1, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000);
      add("d5",  0, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0000, 4'b0000);
      add("d6",  0, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 4'b0000);
      add("d7",  0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000);

      foreach (vecs[i]) begin
         @(negedge Clk);
         Reset     = vecs[i].rst;
         WR_Sync   = vecs[i].sync;
         WR_Clear  = vecs[i].clr;
         Grant_Ack = vecs[i].ack;
         sb.push_back(vecs[i]);
         @(posedge Clk);
         #1;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty at vector %0d", i);
         end else begin
            e = sb.pop_front();
            chk({e.tag, ".wr"},      8'(WR),            8'(e.wr));
            chk({e.tag, ".grant"},   8'(Grant),         8'(e.gnt));
            chk({e.tag, ".gvalid"},  8'(Grant_Valid),   8'(|e.gnt));
            chk({e.tag, ".pcount"},  8'(Pending_Count), 8'($countones(e.wr)));
            chk({e.tag, ".urgent"},  8'(Urgent),        8'(e.urg));
            chk({e.tag, ".anyurg"},  8'(Any_Urgent),    8'(|e.urg));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
